// File: rtl/sdram_frame_reader.sv
// Raster timing generator that drains the SDRAM read FIFO into a video port.
// Reloads the FIFO once per frame in vertical blanking to keep frames aligned.
module sdram_frame_reader #(
  parameter int DSIZE       = 16,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int PREFILL     = 8,
  parameter int LOAD_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [DSIZE-1:0] RD_DATA,
  input  logic             RD_EMPTY,
  input  logic [15:0]      RD_USE,
  output logic             RD,
  output logic             RD_LOAD,
  output logic [DSIZE-1:0] PIX_DATA,
  output logic             PIX_DE,
  output logic             PIX_HS,
  output logic             PIX_VS,
  output logic             FRAME_START,
  output logic             UNDERFLOW,
  input  logic             UNDERFLOW_CLR
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int LW = $clog2(LOAD_CYCLES + 1);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_BLANK   = VW'(V_ACTIVE);
  localparam logic [LW-1:0] LOAD_INIT = LW'(LOAD_CYCLES - 1);
  localparam logic [15:0]   PREFILL_W = 16'(PREFILL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_PREFILL,
    S_RUN,
    S_RESYNC
  } state_t;

  state_t state;

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [LW-1:0] load_cnt;

  logic running;
  logic active;
  logic hs_n;
  logic vs_n;
  logic first;

  logic act1;
  logic hs1;
  logic vs1;
  logic fire1;
  logic first1;

  always_comb begin
    running = (state == S_RUN) || (state == S_RESYNC);
    active  = running
            && (32'(h) < H_ACTIVE)
            && (32'(v) < V_ACTIVE);
    hs_n = !(running
            && (32'(h) >= H_ACTIVE + H_FP)
            && (32'(h) < H_ACTIVE + H_FP + H_SYNC));
    vs_n = !(running
            && (32'(v) >= V_ACTIVE + V_FP)
            && (32'(v) < V_ACTIVE + V_FP + V_SYNC));
    first = active && (h == '0) && (v == '0);
    RD    = active && !RD_EMPTY && !RD_LOAD;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_IDLE;
      h           <= '0;
      v           <= '0;
      load_cnt    <= '0;
      RD_LOAD     <= 1'b0;
      act1        <= 1'b0;
      hs1         <= 1'b1;
      vs1         <= 1'b1;
      fire1       <= 1'b0;
      first1      <= 1'b0;
      PIX_DATA    <= '0;
      PIX_DE      <= 1'b0;
      PIX_HS      <= 1'b1;
      PIX_VS      <= 1'b1;
      FRAME_START <= 1'b0;
      UNDERFLOW   <= 1'b0;
    end else begin
      // Stage 1 is squashed on disable so the port blanks two edges later.
      act1   <= active && ENABLE;
      hs1    <= hs_n || !ENABLE;
      vs1    <= vs_n || !ENABLE;
      fire1  <= RD && ENABLE;
      first1 <= first && ENABLE;

      PIX_DATA    <= fire1 ? RD_DATA : '0;
      PIX_DE      <= act1;
      PIX_HS      <= hs1;
      PIX_VS      <= vs1;
      FRAME_START <= first1;

      if (act1 && !fire1) begin
        UNDERFLOW <= 1'b1;
      end else if (UNDERFLOW_CLR) begin
        UNDERFLOW <= 1'b0;
      end

      if (!ENABLE) begin
        state    <= S_IDLE;
        h        <= '0;
        v        <= '0;
        load_cnt <= '0;
        RD_LOAD  <= 1'b0;
      end else begin
        if (running) begin
          if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
          end else begin
            h <= h + 1'b1;
          end
        end

        unique case (state)
          S_IDLE: begin
            state    <= S_FLUSH;
            RD_LOAD  <= 1'b1;
            load_cnt <= LOAD_INIT;
          end
          S_FLUSH: begin
            if (load_cnt == '0) begin
              RD_LOAD <= 1'b0;
              state   <= S_PREFILL;
            end else begin
              load_cnt <= load_cnt - 1'b1;
            end
          end
          S_PREFILL: begin
            if (RD_USE >= PREFILL_W) begin
              state <= S_RUN;
            end
          end
          S_RUN: begin
            if ((h == '0) && (v == V_BLANK)) begin
              state    <= S_RESYNC;
              RD_LOAD  <= 1'b1;
              load_cnt <= LOAD_INIT;
            end
          end
          S_RESYNC: begin
            if (load_cnt == '0) begin
              RD_LOAD <= 1'b0;
              state   <= S_RUN;
            end else begin
              load_cnt <= load_cnt - 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Directed bench for sdram_frame_reader on a 14x7 raster with a modelled FIFO.
// Expected pixels come from a raster model built on the timing constants.
module tb_sdram_frame_reader;

  localparam int DW = 16;
  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HSW = 2;
  localparam int HB = 2;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VSW = 1;
  localparam int VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int NJ = 4 * HT * VT;
  localparam logic [15:0] BASE = 16'h1000;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          ENABLE;
  logic [DW-1:0] RD_DATA = '0;
  logic          RD_EMPTY;
  logic [15:0]   RD_USE;
  logic          RD;
  logic          RD_LOAD;
  logic [DW-1:0] PIX_DATA;
  logic          PIX_DE;
  logic          PIX_HS;
  logic          PIX_VS;
  logic          FRAME_START;
  logic          UNDERFLOW;
  logic          UNDERFLOW_CLR;

  logic [15:0] ptr = '0;
  bit emp [0:511];
  bit clrv [0:511];

  int errors = 0;
  int checks = 0;

  sdram_frame_reader #(
    .DSIZE(DW),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .PREFILL(8), .LOAD_CYCLES(4)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .ENABLE(ENABLE),
    .RD_DATA(RD_DATA),
    .RD_EMPTY(RD_EMPTY),
    .RD_USE(RD_USE),
    .RD(RD),
    .RD_LOAD(RD_LOAD),
    .PIX_DATA(PIX_DATA),
    .PIX_DE(PIX_DE),
    .PIX_HS(PIX_HS),
    .PIX_VS(PIX_VS),
    .FRAME_START(FRAME_START),
    .UNDERFLOW(UNDERFLOW),
    .UNDERFLOW_CLR(UNDERFLOW_CLR)
  );

  always #5 CLK = ~CLK;

  // FIFO model: data one cycle after RD, reload rewinds to word 0.
  always @(posedge CLK) begin
    if (RD_LOAD) begin
      ptr <= '0;
    end else if (RD) begin
      RD_DATA <= BASE + ptr;
      ptr     <= ptr + 16'd1;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_rd"}, 32'(RD), 32'd0);
    chk({pfx, "_rdload"}, 32'(RD_LOAD), 32'd0);
    chk({pfx, "_data"}, 32'(PIX_DATA), 32'd0);
    chk({pfx, "_de"}, 32'(PIX_DE), 32'd0);
    chk({pfx, "_hs"}, 32'(PIX_HS), 32'd1);
    chk({pfx, "_vs"}, 32'(PIX_VS), 32'd1);
    chk({pfx, "_fs"}, 32'(FRAME_START), 32'd0);
    chk({pfx, "_uf"}, 32'(UNDERFLOW), 32'd0);
  endtask

  initial begin
    int h, v, hk, vk, k, miss, rdc, dec, hsc, vsc;
    logic act, dek, ufx;
    logic [15:0] dexp;

    RESET = 1'b1;
    ENABLE = 1'b0;
    RD_EMPTY = 1'b0;
    RD_USE = 16'd0;
    UNDERFLOW_CLR = 1'b0;
    emp[199] = 1'b1;
    clrv[205] = 1'b1;
    emp[215] = 1'b1;
    clrv[216] = 1'b1;

    repeat (3) tick();
    chk_reset("rst");
    RESET = 1'b0;
    tick();
    chk("idle_rdload", 32'(RD_LOAD), 32'd0);

    ENABLE = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("flush_load%0d", i), 32'(RD_LOAD), 32'(i < 4));
      chk($sformatf("flush_rd%0d", i), 32'(RD), 32'd0);
    end
    RD_USE = 16'd7;
    repeat (3) tick();
    chk("prefill7_rd", 32'(RD), 32'd0);
    chk("prefill7_de", 32'(PIX_DE), 32'd0);
    RD_USE = 16'd8;

    miss = 0;
    ufx = 1'b0;
    rdc = 0;
    dec = 0;
    hsc = 0;
    vsc = 0;
    for (int j = 0; j < NJ; j++) begin
      tick();
      RD_EMPTY = emp[j];
      UNDERFLOW_CLR = clrv[j];
      #1;
      h = j % HT;
      v = (j / HT) % VT;
      act = (h < HA) && (v < VA);
      chk($sformatf("rd@%0d", j), 32'(RD), 32'(act && !emp[j]));
      chk($sformatf("rdload@%0d", j), 32'(RD_LOAD),
          32'(v == VA && h >= 1 && h <= 4));
      rdc += int'(RD);
      if (j >= 2) begin
        k = j - 2;
        hk = k % HT;
        vk = (k / HT) % VT;
        dek = (hk < HA) && (vk < VA);
        if (hk == 0 && vk == 0) miss = 0;
        if (!dek || emp[k]) dexp = 16'd0;
        else dexp = BASE + 16'(vk * HA + hk - miss);
        if (dek && emp[k]) begin
          miss++;
          ufx = 1'b1;
        end else if (clrv[j-1]) begin
          ufx = 1'b0;
        end
        chk($sformatf("de@%0d", k), 32'(PIX_DE), 32'(dek));
        chk($sformatf("data@%0d", k), 32'(PIX_DATA), 32'(dexp));
        chk($sformatf("hs@%0d", k), 32'(PIX_HS),
            32'(!(hk >= HA + HF && hk < HA + HF + HSW)));
        chk($sformatf("vs@%0d", k), 32'(PIX_VS),
            32'(!(vk >= VA + VF && vk < VA + VF + VSW)));
        chk($sformatf("fs@%0d", k), 32'(FRAME_START),
            32'(dek && hk == 0 && vk == 0));
        chk($sformatf("uf@%0d", k), 32'(UNDERFLOW), 32'(ufx));
        dec += int'(PIX_DE);
        hsc += int'(!PIX_HS);
        vsc += int'(!PIX_VS);
      end else begin
        chk($sformatf("pre_de@%0d", j), 32'(PIX_DE), 32'd0);
        chk($sformatf("pre_uf@%0d", j), 32'(UNDERFLOW), 32'd0);
      end
    end
    RD_EMPTY = 1'b0;
    UNDERFLOW_CLR = 1'b0;
    chk("rd_count", 32'(rdc), 32'd126);
    chk("de_count", 32'(dec), 32'd128);
    chk("hs_count", 32'(hsc), 32'd56);
    chk("vs_count", 32'(vsc), 32'd56);

    repeat (4) tick();
    chk("mid_rd", 32'(RD), 32'd1);
    ENABLE = 1'b0;
    tick();
    chk("dis_rd", 32'(RD), 32'd0);
    chk("dis_rdload", 32'(RD_LOAD), 32'd0);
    tick();
    chk("dis_de", 32'(PIX_DE), 32'd0);
    chk("dis_data", 32'(PIX_DATA), 32'd0);
    chk("dis_hs", 32'(PIX_HS), 32'd1);
    chk("dis_vs", 32'(PIX_VS), 32'd1);
    chk("dis_uf_held", 32'(UNDERFLOW), 32'd1);

    ENABLE = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("reen_load%0d", i), 32'(RD_LOAD), 32'(i <= 4));
      chk($sformatf("reen_rd%0d", i), 32'(RD), 32'(i == 6));
    end
    tick();
    tick();
    chk("reen_fs", 32'(FRAME_START), 32'd1);
    chk("reen_de", 32'(PIX_DE), 32'd1);
    chk("reen_data", 32'(PIX_DATA), 32'(BASE));

    RD_EMPTY = 1'b1;
    #1;
    chk("empty_rd", 32'(RD), 32'd0);
    tick();
    tick();
    chk("empty_de", 32'(PIX_DE), 32'd1);
    chk("empty_data", 32'(PIX_DATA), 32'd0);
    chk("empty_uf", 32'(UNDERFLOW), 32'd1);

    RD_EMPTY = 1'b0;
    RESET = 1'b1;
    tick();
    chk_reset("midrst");
    RESET = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
